// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the pipeline hazard logic.
//   hz_state_t    : hazard controller FSM state (RUN, DMEM_WAIT, REDIRECT)
//   STALL_CNT_W   : width of the optional stall-cycle performance counter
//   load_use_hit  : detects a load in ID/EX feeding a source of IF/ID
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int STALL_CNT_W = 32;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        REDIRECT  = 2'd2
    } hz_state_t;

    // x0 is hard-wired to zero, so a load targeting it never creates a
    // real dependency and must not stall the pipeline.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return mem_read && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/hazard_stall_counter.sv
// ----------------------------------------------------------------------------
// hazard_stall_counter
// Free-running count of cycles in which the PC was held. Wraps naturally
// from all-ones back to zero.
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset, clears the count
//   stall_i : 1 in every cycle the PC is not written
//   count_o : accumulated stall cycles
// ----------------------------------------------------------------------------
module hazard_stall_counter
    import riscv_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall_i,
    output logic [STALL_CNT_W-1:0] count_o
);

    logic [STALL_CNT_W-1:0] cnt_q;
    logic [STALL_CNT_W-1:0] cnt_d;

    assign cnt_d = stall_i ? cnt_q + STALL_CNT_W'(1) : cnt_q;

    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/hazard_controller.sv
// ----------------------------------------------------------------------------
// hazard_controller
// Stall/flush control for a 5-stage in-order pipeline. Outputs are
// combinational from the FSM state and the current hazard inputs.
//   clk, reset                 : clock, synchronous active-high reset
//   id_rs1, id_rs2             : IF/ID source registers
//   idex_rd, idex_mem_read     : ID/EX destination and load flag
//   exmem_branch_inst/_taken   : resolved branch at the EX/MEM output
//   exmem_mem_read/_write      : memory access at the EX/MEM output
//   dmem_ready, imem_ready     : memory handshakes
//   *_write_en                 : 0 holds the stage register
//   *_flush                    : 1 loads a bubble into the stage register
//   stall_cycles               : PC-hold cycle count (HAZARD_PERF_CNT_EN only)
// Build option: define HAZARD_PERF_CNT_EN to add the stall_cycles counter.
// ----------------------------------------------------------------------------
module hazard_controller
    import riscv_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic [4:0]             idex_rd,
    input  logic                   idex_mem_read,
    input  logic                   exmem_branch_inst,
    input  logic                   exmem_branch_taken,
    input  logic                   exmem_mem_read,
    input  logic                   exmem_mem_write,
    input  logic                   dmem_ready,
    input  logic                   imem_ready,
    output logic                   pc_write_en,
    output logic                   ifid_write_en,
    output logic                   idex_write_en,
    output logic                   exmem_write_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   exmem_flush,
    output logic                   memwb_flush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

    hz_state_t state_q;
    hz_state_t state_d;

    logic branch_taken;
    logic load_use;
    logic dmem_stall;

    assign branch_taken = exmem_branch_inst & exmem_branch_taken;
    assign load_use     = load_use_hit(idex_mem_read, idex_rd, id_rs1, id_rs2);

    // A miss seen in RUN, or any DMEM_WAIT cycle still lacking ready. Once
    // ready arrives in DMEM_WAIT the cycle falls through to the RUN rules.
    assign dmem_stall = ((exmem_mem_read | exmem_mem_write) & ~dmem_ready)
                      | ((state_q == DMEM_WAIT) & ~dmem_ready);

    // NOTE: every output and state_d gets a default first so no path
    // through the block leaves a value unassigned (which would infer a latch).
    always_comb begin
        state_d        = RUN;
        pc_write_en    = 1'b1;
        ifid_write_en  = 1'b1;
        idex_write_en  = 1'b1;
        exmem_write_en = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        exmem_flush    = 1'b0;
        memwb_flush    = 1'b0;

        if (reset) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (state_q == REDIRECT) begin
            // Hold the PC and keep discarding the stale fetch until the
            // redirected fetch has been accepted.
            pc_write_en = 1'b0;
            ifid_flush  = 1'b1;
            state_d     = imem_ready ? RUN : REDIRECT;
        end else if (dmem_stall) begin
            // Freeze everything up to EX/MEM (a pending branch stays held
            // in EX/MEM) and drain a bubble into MEM/WB.
            pc_write_en    = 1'b0;
            ifid_write_en  = 1'b0;
            idex_write_en  = 1'b0;
            exmem_write_en = 1'b0;
            memwb_flush    = 1'b1;
            state_d        = DMEM_WAIT;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = imem_ready ? RUN : REDIRECT;
        end else if (load_use || !imem_ready) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_flush    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_stall_counter u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .stall_i (~pc_write_en),
        .count_o (stall_cycles)
    );
`endif

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

    // Output vector order: {pc, ifid, idex, exmem write_en, ifid, idex, exmem, memwb flush}
    localparam logic [7:0] O_DEF   = 8'b1111_0000;
    localparam logic [7:0] O_TAKEN = 8'b1111_1110;
    localparam logic [7:0] O_HOLD  = 8'b0011_0100;
    localparam logic [7:0] O_MISS  = 8'b0000_0001;
    localparam logic [7:0] O_REDIR = 8'b0111_1000;
    localparam logic [7:0] O_RST   = 8'b1111_1111;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, idex_rd;
    logic       idex_mem_read, exmem_branch_inst, exmem_branch_taken;
    logic       exmem_mem_read, exmem_mem_write, dmem_ready, imem_ready;
    logic       pc_write_en, ifid_write_en, idex_write_en, exmem_write_en;
    logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       ld;
        logic       br_inst;
        logic       br_taken;
        logic       m_rd;
        logic       m_wr;
        logic       dmem_rdy;
        logic       imem_rdy;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[13];

    hazard_controller dut (
        .clk                (clk),
        .reset              (reset),
        .id_rs1             (id_rs1),
        .id_rs2             (id_rs2),
        .idex_rd            (idex_rd),
        .idex_mem_read      (idex_mem_read),
        .exmem_branch_inst  (exmem_branch_inst),
        .exmem_branch_taken (exmem_branch_taken),
        .exmem_mem_read     (exmem_mem_read),
        .exmem_mem_write    (exmem_mem_write),
        .dmem_ready         (dmem_ready),
        .imem_ready         (imem_ready),
        .pc_write_en        (pc_write_en),
        .ifid_write_en      (ifid_write_en),
        .idex_write_en      (idex_write_en),
        .exmem_write_en     (exmem_write_en),
        .ifid_flush         (ifid_flush),
        .idex_flush         (idex_flush),
        .exmem_flush        (exmem_flush),
        .memwb_flush        (memwb_flush)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles       (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {pc_write_en, ifid_write_en, idex_write_en, exmem_write_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush};
    endfunction

    task automatic check_outs(input string name, input logic [7:0] exp);
        check(name, 32'(outs()), 32'(exp));
    endtask

    task automatic check_cnt(input string name, input logic [31:0] exp);
`ifdef HAZARD_PERF_CNT_EN
        check(name, stall_cycles, exp);
`endif
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; idex_rd = 5'd0;
        idex_mem_read = 1'b0; exmem_branch_inst = 1'b0; exmem_branch_taken = 1'b0;
        exmem_mem_read = 1'b0; exmem_mem_write = 1'b0;
        dmem_ready = 1'b1; imem_ready = 1'b1;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        #1 check_outs(name, O_RST);
        step();
        reset = 1'b0;
        clear_inputs();
        #1 check_cnt({name, "_cnt"}, 32'd0);
    endtask

    initial begin
        //            rs1    rs2    rd     ld    bi    bt    mr    mw    drdy  irdy  expected
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_DEF};
        vecs[1]  = '{5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_HOLD};
        vecs[2]  = '{5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_HOLD};
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_DEF};
        vecs[4]  = '{5'd9, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_DEF};
        vecs[5]  = '{5'd4, 5'd6, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_DEF};
        vecs[6]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, O_TAKEN};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_DEF};
        vecs[8]  = '{5'd3, 5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, O_TAKEN};
        vecs[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_HOLD};
        vecs[10] = '{5'd2, 5'd2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_HOLD};
        vecs[11] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, O_DEF};
        vecs[12] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_DEF};

        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        #1 check_outs("reset_outs", O_RST);
        step();
        reset = 1'b0;
        #1 check_outs("post_reset_default", O_DEF);
        check_cnt("post_reset_cnt", 32'd0);

        // Single-cycle RUN behaviour; no vector leaves the RUN state.
        for (int i = 0; i < 13; i++) begin
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; idex_rd = vecs[i].rd;
            idex_mem_read = vecs[i].ld;
            exmem_branch_inst = vecs[i].br_inst; exmem_branch_taken = vecs[i].br_taken;
            exmem_mem_read = vecs[i].m_rd; exmem_mem_write = vecs[i].m_wr;
            dmem_ready = vecs[i].dmem_rdy; imem_ready = vecs[i].imem_rdy;
            #1 check_outs($sformatf("vec%0d", i), vecs[i].exp);
            step();
        end
        clear_inputs();
        #1 check_cnt("table_cnt", 32'd4);

        // Data-memory miss, 3 cycles, with a taken branch held in EX/MEM.
        do_reset("rst_before_miss");
        exmem_mem_read = 1'b1; dmem_ready = 1'b0;
        exmem_branch_inst = 1'b1; exmem_branch_taken = 1'b1;
        #1 check_outs("miss_c1", O_MISS);
        step();
        #1 check_outs("miss_c2", O_MISS);
        step();
        #1 check_outs("miss_c3", O_MISS);
        step();
        dmem_ready = 1'b1;
        #1 check_outs("miss_release_branch", O_TAKEN);
        check_cnt("miss_cnt", 32'd3);
        step();
        clear_inputs();
        dmem_ready = 1'b0; imem_ready = 1'b0;
        #1 check_outs("miss_back_in_run", O_HOLD);
        step();

        // Taken branch while fetch is stalled, then 3 REDIRECT cycles.
        do_reset("rst_before_redirect");
        exmem_branch_inst = 1'b1; exmem_branch_taken = 1'b1; imem_ready = 1'b0;
        #1 check_outs("branch_imem_stall", O_TAKEN);
        step();
        clear_inputs();
        imem_ready = 1'b0;
        #1 check_outs("redirect_c1", O_REDIR);
        step();
        #1 check_outs("redirect_c2", O_REDIR);
        step();
        imem_ready = 1'b1;
        #1 check_outs("redirect_c3", O_REDIR);
        step();
        #1 check_outs("redirect_exit", O_DEF);
        check_cnt("redirect_cnt", 32'd3);
        step();

        // Reset in the second DMEM_WAIT cycle.
        clear_inputs();
        exmem_mem_read = 1'b1; dmem_ready = 1'b0;
        #1 check_outs("rdw_miss", O_MISS);
        step();
        #1 check_outs("rdw_wait1", O_MISS);
        step();
        reset = 1'b1;
        #1 check_outs("rdw_reset_outs", O_RST);
        step();
        reset = 1'b0;
        clear_inputs();
        dmem_ready = 1'b0; imem_ready = 1'b0;
        #1 check_outs("rdw_back_in_run", O_HOLD);
        check_cnt("rdw_cnt", 32'd0);
        step();

        // Reset in REDIRECT.
        clear_inputs();
        exmem_branch_inst = 1'b1; exmem_branch_taken = 1'b1; imem_ready = 1'b0;
        #1 check_outs("rrd_branch", O_TAKEN);
        step();
        exmem_branch_inst = 1'b0; exmem_branch_taken = 1'b0;
        reset = 1'b1;
        #1 check_outs("rrd_reset_outs", O_RST);
        step();
        reset = 1'b0;
        clear_inputs();
        #1 check_outs("rrd_back_in_run", O_DEF);
        step();

`ifdef HAZARD_PERF_CNT_EN
        // Counter wrap from all-ones on a load-use stall.
        clear_inputs();
        idex_mem_read = 1'b1; idex_rd = 5'd5; id_rs2 = 5'd5;
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFF;
        #1 check("wrap_preload", stall_cycles, 32'hFFFF_FFFF);
        check_outs("wrap_load_use", O_HOLD);
        release dut.u_stall_cnt.cnt_q;
        step();
        clear_inputs();
        #1 check("wrap_zero", stall_cycles, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock), then reset (input, 1, synchronous active-high reset).
REQ-002 id_rs1, id_rs2  input  5  source registers of the instruction in IF/ID.
REQ-003 idex_rd  input  5  and idex_mem_read  input  1  destination and load flag of the instruction in ID/EX.
REQ-004 exmem_branch_inst, exmem_branch_taken  input  1 each  branch decision at the EX/MEM register output.
REQ-005 exmem_mem_read, exmem_mem_write  input  1 each  memory access at the EX/MEM register output.
REQ-006 dmem_ready, imem_ready  input  1 each  data and instruction memory ready.
REQ-007 pc_write_en, ifid_write_en, idex_write_en, exmem_write_en  output  1 each  stage hold when 0.
REQ-008 ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  load a bubble when 1.
REQ-009 stall_cycles  output  32  stall counter, present only under HAZARD_PERF_CNT_EN.

Function
REQ-010 SHALL implement the FSM states RUN, DMEM_WAIT and REDIRECT.
REQ-011 Default (RUN, no hazard): all write_en = 1 and all flush = 0.
REQ-012 Taken branch:
- Condition: RUN with exmem_branch_inst & exmem_branch_taken.
- SHALL assert ifid_flush, idex_flush and exmem_flush, with pc_write_en = 1.
- If imem_ready = 0 that cycle, SHALL go to REDIRECT.
REQ-013 Load-use:
- Condition: RUN, no taken branch, idex_mem_read & idex_rd != 0 & (idex_rd == id_rs1 | idex_rd == id_rs2).
- SHALL set pc_write_en = 0, ifid_write_en = 0 and idex_flush = 1 for that single cycle.
REQ-014 Data-memory miss:
- Condition: RUN with (exmem_mem_read | exmem_mem_write) & !dmem_ready.
- SHALL enter DMEM_WAIT on the next edge.
- In that cycle and every DMEM_WAIT cycle: all write_en = 0 and memwb_flush = 1.
REQ-015 DMEM_WAIT SHALL return to RUN on the edge where dmem_ready = 1; that cycle SHALL be treated as RUN (outputs per REQ-011 to REQ-013).
REQ-016 Instruction-memory stall: RUN with imem_ready = 0 and no other hazard SHALL set pc_write_en = 0, ifid_write_en = 0 and idex_flush = 1.
REQ-017 REDIRECT:
- SHALL hold pc_write_en = 0 and assert ifid_flush every cycle, discarding the stale fetch.
- SHALL return to RUN on the edge after imem_ready = 1.
REQ-018 Priority SHALL be: DMEM_WAIT/miss > taken branch > load-use > imem stall.
- A branch in EX/MEM during a miss SHALL be held, not acted on, until the miss clears.
REQ-019 Outputs SHALL be combinational from state and inputs: zero-cycle latency. The FSM SHALL be the only state besides the counter.
REQ-020 Load-use detection SHALL ignore rd = x0.

Reset
REQ-021 Reset SHALL be synchronous, active-high, dominating all inputs.
REQ-022 While reset = 1, the FSM SHALL go to RUN with all flush = 1 and all write_en = 1.
REQ-023 Reset SHALL zero stall_cycles when it is present.
REQ-024 Reset mid-DMEM_WAIT or mid-REDIRECT SHALL return to RUN on the same edge, with no residual stall.

Configuration
REQ-025 Macro HAZARD_PERF_CNT_EN defined:
- stall_cycles SHALL increment by 1 each cycle in which pc_write_en = 0.
- It SHALL wrap from 0xFFFFFFFF to 0.
REQ-026 Macro undefined: the port and the counter logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 The hz_state_t enum (RUN, DMEM_WAIT, REDIRECT) and STALL_CNT_W = 32 SHALL live in the shared package riscv_pkg.
REQ-028 The counter SHALL be the single sub-module hazard_stall_counter, instantiated only under HAZARD_PERF_CNT_EN.

Verification
REQ-029 Load-use:
- Stimulus: idex_mem_read = 1, idex_rd = 5, id_rs2 = 5.
- Response: one cycle with pc_write_en = 0, ifid_write_en = 0, idex_flush = 1, then the default.
REQ-030 Data-memory miss:
- Stimulus: exmem_mem_read = 1, dmem_ready = 0 for 3 cycles, then 1.
- Response: 3 cycles with all write_en = 0 and memwb_flush = 1, then RUN; stall_cycles = 3.
REQ-031 Branch with fetch stall:
- Stimulus: taken branch with imem_ready = 0, then imem_ready = 0, 0, 1.
- Response: ifid/idex/exmem_flush = 1 in the branch cycle, then REDIRECT with ifid_flush = 1 for 3 cycles, then RUN.
REQ-032 Simultaneous events:
- Stimulus: taken branch plus load-use match in the same cycle.
- Response: branch flush only; pc_write_en = 1.
REQ-033 Reset mid-operation:
- Stimulus: reset asserted in the second DMEM_WAIT cycle.
- Response: RUN next cycle, all flush = 1 during reset, stall_cycles = 0.
REQ-034 Counter wrap:
- Stimulus: stall_cycles preloaded (via force) to 0xFFFFFFFF, then one load-use stall.
- Response: stall_cycles = 0.
